mlp_input_loader: RTL and testbench

Upstream feeder for `n_neuron_mlp`. It accepts a serial stream of signed WIDTH-bit samples over a valid/ready handshake and packs every N consecutive samples into one input vector. It then launches the MLP with a one-cycle `soc` and holds the vector stable until the MLP returns `eoc`. Two vector banks are used, so the next vector fills while the MLP computes on the current one.

---
 rtl/mlp_pkg.sv | 24 ++
 rtl/mlp_input_bank.sv | 42 ++++
 rtl/mlp_input_loader.sv | 177 +++++++++++++++++
 tb/tb_mlp_input_loader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_pkg.sv
// -----------------------------------------------------------------------------
// mlp_pkg
// Shared definitions for the MLP datapath and its input loader.
//   MLP_N          default number of MLP inputs (samples per vector)
//   MLP_WIDTH      default sample / data width in bits
//   loader_state_t launch FSM states of mlp_input_loader
//   idx_width()    bit width needed to index N entries (at least 1)
// -----------------------------------------------------------------------------
package mlp_pkg;

    localparam int MLP_N     = 5;
    localparam int MLP_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } loader_state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mlp_input_bank.sv
// -----------------------------------------------------------------------------
// mlp_input_bank
// One N-entry sample bank with a single indexed write port and a parallel
// read port exposing all N entries at once.
//   clk    clock
//   rst_n  asynchronous active-low clear (all entries to zero)
//   we     write enable
//   widx   entry written when we is high
//   wdata  sample to write
//   rdata  all entries, entry 0 in the least significant slot
// -----------------------------------------------------------------------------
module mlp_input_bank
    import mlp_pkg::*;
#(
    parameter int N     = MLP_N,
    parameter int WIDTH = MLP_WIDTH,
    localparam int IDX_W = idx_width(N)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [IDX_W-1:0]        widx,
    input  logic signed [WIDTH-1:0] wdata,
    output logic [N-1:0][WIDTH-1:0] rdata
);

    logic [N-1:0][WIDTH-1:0] mem_r;

    // Sample storage: one entry written per accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_r <= '0;
        end else if (we) begin
            mem_r[widx] <= wdata;
        end else begin
            mem_r <= mem_r;
        end
    end

    assign rdata = mem_r;

endmodule

// File: rtl/mlp_input_loader.sv
// -----------------------------------------------------------------------------
// mlp_input_loader
// Packs a serial valid/ready stream of signed samples into N-sample vectors
// held in two ping-pong banks, and launches the MLP on each completed vector.
//   clk       clock
//   rst_n     asynchronous active-low reset
//   in_valid  upstream sample valid
//   in_data   upstream sample
//   in_ready  a sample can be accepted this cycle
//   soc       one-cycle start-of-computation pulse to the MLP
//   vec       vector under computation (two's complement entries, entry 0 =
//             first sample of the vector)
//   eoc       end-of-computation from the MLP (only honoured in BUSY)
//   busy      a computation is outstanding
// -----------------------------------------------------------------------------
module mlp_input_loader
    import mlp_pkg::*;
#(
    parameter int N     = MLP_N,
    parameter int WIDTH = MLP_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic signed [WIDTH-1:0] in_data,
    output logic                    in_ready,
    output logic                    soc,
    output logic [N-1:0][WIDTH-1:0] vec,
    input  logic                    eoc,
    output logic                    busy
);

    localparam int IDX_W = idx_width(N);

    loader_state_t           state_r;
    logic                    soc_r;
    logic                    busy_r;
    logic [1:0]              full_r;
    logic                    fill_bank_r;
    logic                    exec_bank_r;
    logic [IDX_W-1:0]        fill_idx_r;

    logic                    in_ready_s;
    logic                    accept_s;
    logic                    last_s;
    logic                    release_s;
    logic [1:0]              we_s;
    logic [1:0]              full_next_s;
    logic [N-1:0][WIDTH-1:0] rdata0_s;
    logic [N-1:0][WIDTH-1:0] rdata1_s;
    logic [N-1:0][WIDTH-1:0] vec_s;

    // Handshake, bank write enables and bank read selection.
    always_comb begin
        in_ready_s = ~full_r[fill_bank_r];
        accept_s   = in_valid & in_ready_s;
        last_s     = (fill_idx_r == IDX_W'(N - 1));
        release_s  = (state_r == BUSY) & eoc;
        we_s       = 2'b00;
        we_s[fill_bank_r] = accept_s;
        if (exec_bank_r) begin
            vec_s = rdata1_s;
        end else begin
            vec_s = rdata0_s;
        end
    end

    // Next full flags: release and completion may hit the two banks in the
    // same cycle; they never target the same bank because a full bank is
    // never the one being filled.
    always_comb begin
        full_next_s = full_r;
        if (release_s) begin
            full_next_s[exec_bank_r] = 1'b0;
        end else begin
            full_next_s = full_next_s;
        end
        if (accept_s && last_s) begin
            full_next_s[fill_bank_r] = 1'b1;
        end else begin
            full_next_s = full_next_s;
        end
    end

    // Fill side: sample index within the vector and the bank being filled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_idx_r  <= '0;
            fill_bank_r <= 1'b0;
        end else if (accept_s) begin
            if (last_s) begin
                fill_idx_r  <= '0;
                fill_bank_r <= ~fill_bank_r;
            end else begin
                fill_idx_r  <= fill_idx_r + IDX_W'(1);
            end
        end else begin
            fill_idx_r  <= fill_idx_r;
        end
    end

    // Per-bank full flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_r <= 2'b00;
        end else begin
            full_r <= full_next_s;
        end
    end

    // Launch FSM with registered soc/busy and the bank under computation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            soc_r       <= 1'b0;
            busy_r      <= 1'b0;
            exec_bank_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (full_r[exec_bank_r]) begin
                        state_r <= START;
                        soc_r   <= 1'b1;
                        busy_r  <= 1'b1;
                    end else begin
                        soc_r   <= 1'b0;
                        busy_r  <= 1'b0;
                    end
                end
                START: begin
                    state_r <= BUSY;
                    soc_r   <= 1'b0;
                    busy_r  <= 1'b1;
                end
                BUSY: begin
                    soc_r <= 1'b0;
                    if (eoc) begin
                        state_r     <= IDLE;
                        busy_r      <= 1'b0;
                        exec_bank_r <= ~exec_bank_r;
                    end else begin
                        busy_r      <= 1'b1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    soc_r   <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    mlp_input_bank #(.N(N), .WIDTH(WIDTH)) u_bank0 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s[0]),
        .widx  (fill_idx_r),
        .wdata (in_data),
        .rdata (rdata0_s)
    );

    mlp_input_bank #(.N(N), .WIDTH(WIDTH)) u_bank1 (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we_s[1]),
        .widx  (fill_idx_r),
        .wdata (in_data),
        .rdata (rdata1_s)
    );

    assign in_ready = in_ready_s;
    assign soc      = soc_r;
    assign busy     = busy_r;
    assign vec      = vec_s;

endmodule

// File: tb/tb_mlp_input_loader.sv
// -----------------------------------------------------------------------------
// tb_mlp_input_loader
// Scoreboard bench for mlp_input_loader (N=5, WIDTH=8). A reference model
// tracks completed-but-unreleased vectors and launch timing, pushing each
// completed vector into a queue; a monitor pops it on every soc and compares
// vec, then checks vec stays stable while busy.
// -----------------------------------------------------------------------------
module tb_mlp_input_loader;
    import mlp_pkg::*;

    localparam int N = 5;
    localparam int W = 8;

    typedef logic [N-1:0][W-1:0] vec_t;

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                in_valid = 1'b0;
    logic signed [W-1:0] in_data = '0;
    logic                eoc = 1'b0;
    logic                in_ready;
    logic                soc;
    logic                busy;
    vec_t                vec;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Reference-model state
    vec_t       exp_q[$];
    int         ready_q[$];
    logic [W-1:0] part[$];
    int         n_full = 0;
    int         free_cyc = 0;
    int         start_cyc = -1;
    bit         busy_m = 1'b0;

    mlp_input_loader #(.N(N), .WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .soc      (soc),
        .vec      (vec),
        .eoc      (eoc),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, got, exp);
        end
    endtask

    task automatic drive(input bit v, input logic [W-1:0] d, input bit e);
        @(posedge clk);
        #1;
        in_valid = v;
        in_data  = d;
        eoc      = e;
    endtask

    task automatic check_reset_outputs(input string tag);
        @(negedge clk);
        chk({tag, "_in_ready"}, in_ready, 1'b1);
        chk({tag, "_soc"}, soc, 1'b0);
        chk({tag, "_busy"}, busy, 1'b0);
        chk({tag, "_vec"}, vec, '0);
    endtask

    // Reference model: vectors complete after N accepted samples, at most two
    // may be outstanding, a vector launches two cycles after it completes or
    // two cycles after the previous computation's eoc, whichever is later.
    initial forever begin
        bit exp_ready;
        bit exp_soc;
        int launch_at;
        vec_t v;
        @(negedge clk);
        if (!rst_n) begin
            exp_q.delete();
            ready_q.delete();
            part.delete();
            n_full    = 0;
            free_cyc  = 0;
            start_cyc = -1;
            busy_m    = 1'b0;
        end else begin
            exp_ready = (n_full < 2);
            chk("in_ready", in_ready, exp_ready);
            exp_soc = 1'b0;
            if (!busy_m && ready_q.size() > 0) begin
                launch_at = (ready_q[0] > free_cyc) ? ready_q[0] : free_cyc;
                exp_soc = (cyc >= launch_at);
            end
            chk("soc", soc, exp_soc);
            if (exp_soc) begin
                void'(ready_q.pop_front());
                busy_m    = 1'b1;
                start_cyc = cyc;
            end
            chk("busy", busy, busy_m);
            if (busy_m && cyc != start_cyc && eoc) begin
                n_full--;
                busy_m   = 1'b0;
                free_cyc = cyc + 2;
            end
            if (in_valid && exp_ready) begin
                part.push_back(in_data);
                if (part.size() == N) begin
                    for (int i = 0; i < N; i++) v[i] = part[i];
                    exp_q.push_back(v);
                    ready_q.push_back(cyc + 2);
                    n_full++;
                    part.delete();
                end
            end
        end
    end

    // Monitor: pop the expected vector on each soc and check it is held.
    initial begin
        vec_t held;
        bit   holding;
        holding = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                holding = 1'b0;
            end else if (soc) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL soc_unexpected cycle=%0d got soc=1 expected no pending vector", cyc);
                end else begin
                    held = exp_q.pop_front();
                    chk("vec_at_soc", vec, held);
                    holding = 1'b1;
                end
            end else if (busy && holding) begin
                chk("vec_hold", vec, held);
            end else if (!busy) begin
                holding = 1'b0;
            end
        end
    end

    initial begin
        logic [W-1:0] single_vals [5];
        single_vals[0] = 8'd5;
        single_vals[1] = 8'hFD;
        single_vals[2] = 8'd127;
        single_vals[3] = 8'h80;
        single_vals[4] = 8'd0;

        // Power-on reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        check_reset_outputs("por");
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset mid-fill after three samples, then a fresh vector
        for (int i = 0; i < 3; i++) drive(1'b1, 8'(i + 1), 1'b0);
        @(posedge clk);
        #3;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        check_reset_outputs("midfill");
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < N; i++) drive(1'b1, 8'(8'h40 + i), 1'b0);
        repeat (4) drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b1);
        drive(1'b0, 8'd0, 1'b0);

        // Single vector with boundary values
        for (int i = 0; i < N; i++) drive(1'b1, single_vals[i], 1'b0);
        repeat (6) drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b1);
        repeat (2) drive(1'b0, 8'd0, 1'b0);

        // Double buffering: 10 back-to-back, 11th blocked, then release
        for (int i = 0; i < 2 * N; i++) drive(1'b1, 8'(8'h10 + i), 1'b0);
        repeat (3) drive(1'b1, 8'h99, 1'b0);
        drive(1'b0, 8'd0, 1'b1);
        repeat (4) drive(1'b0, 8'd0, 1'b0);

        // Simultaneous eoc and completion of the other bank
        for (int i = 0; i < N - 1; i++) drive(1'b1, 8'(8'h20 + i), 1'b0);
        drive(1'b1, 8'h2F, 1'b1);
        repeat (4) drive(1'b0, 8'd0, 1'b0);
        drive(1'b0, 8'd0, 1'b1);
        repeat (2) drive(1'b0, 8'd0, 1'b0);

        // Spurious eoc in IDLE and START (eoc held high throughout)
        repeat (3) drive(1'b0, 8'd0, 1'b1);
        for (int i = 0; i < N; i++) drive(1'b1, 8'(8'hA0 + i), 1'b1);
        repeat (4) drive(1'b0, 8'd0, 1'b1);
        repeat (2) drive(1'b0, 8'd0, 1'b0);

        // Randomized traffic with one asynchronous reset in the middle
        for (int k = 0; k < 3000; k++) begin
            drive(($urandom_range(0, 99) < 70), 8'($urandom), ($urandom_range(0, 99) < 15));
            if (k == 1500) begin
                @(posedge clk);
                #2 rst_n = 1'b0;
                check_reset_outputs("rand");
                @(posedge clk);
                #1 rst_n = 1'b1;
            end
        end

        // Drain outstanding computations
        repeat (20) drive(1'b0, 8'd0, 1'b1);
        drive(1'b0, 8'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("drain_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
